// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port, registered occupancy flags and
// sticky overflow/underflow error indicators.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int AFULL_LVL  = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance is gated by the registered flags, so a full FIFO only takes the
  // read and an empty FIFO only takes the write.
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the pointers,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      q            <= '0;
      q_valid      <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AFULL_C);
      almost_empty <= (count_next <= AEMPTY_C);

      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        q_valid   <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        q_valid <= rd_acc;
        if (wr_acc) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_acc) begin
          rd_ptr <= rd_ptr + 1'b1;
          q      <= mem[rd_ptr];
        end
        if (wr_en && full) begin
          overflow <= 1'b1;
        end
        if (rd_en && empty) begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule
